// File: rtl/fcu_rc_pkg.sv
// Shared types and widths for the RC receiver capture block.
// Channel FSM encoding plus result field widths used by the top and channel modules.
package fcu_rc_pkg;

   localparam int WIDTH_W = 16;
   localparam int CHAN_W  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HIGH = 1'b1
   } cap_state_e;

endpackage

// File: rtl/rc_chan_capture.sv
// One RC channel: edge-driven high-time counter, range check, loss timer,
// single-entry pending result with sticky overrun flag.
module rc_chan_capture
   import fcu_rc_pkg::*;
#(
   parameter int MIN_US  = 800,
   parameter int MAX_US  = 2200,
   parameter int LOST_US = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               init_rdy,
   input  logic               l2h,
   input  logic               h2l,
   input  logic               grant,
   input  logic               ovr_clr,
   output logic               pending,
   output logic [WIDTH_W-1:0] width,
   output logic               sig_lost,
   output logic               overrun
);

   cap_state_e         state_q, state_d;
   logic [WIDTH_W-1:0] cnt_q, cnt_d;
   logic [WIDTH_W-1:0] lost_q, lost_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic               pending_q, pending_d;
   logic               sig_lost_q, sig_lost_d;
   logic               overrun_q, overrun_d;
   logic               capture;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (l2h) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end
         end
         ST_HIGH: begin
            if (l2h) begin
               cnt_d = '0;
            end else if (h2l) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               capture = (cnt_q >= WIDTH_W'(MIN_US)) && (cnt_q <= WIDTH_W'(MAX_US));
            end else if (tick) begin
               // The tick that would take the count past MAX_US aborts the capture
               if (cnt_q == WIDTH_W'(MAX_US)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (!init_rdy) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         capture = 1'b0;
      end

      lost_d = lost_q;
      if (capture) begin
         lost_d = '0;
      end else if (tick && (lost_q != WIDTH_W'(LOST_US))) begin
         lost_d = lost_q + 1'b1;
      end
      sig_lost_d = (lost_q == WIDTH_W'(LOST_US));

      // A grant in the same cycle as a capture sends the old value and keeps the new one
      pending_d = pending_q;
      width_d   = width_q;
      overrun_d = overrun_q;
      if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      if (capture) begin
         pending_d = 1'b1;
         width_d   = cnt_q;
         if (pending_q && !grant) begin
            overrun_d = 1'b1;
         end
      end else if (grant) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lost_q     <= WIDTH_W'(LOST_US);
         width_q    <= '0;
         pending_q  <= 1'b0;
         sig_lost_q <= 1'b1;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lost_q     <= lost_d;
         width_q    <= width_d;
         pending_q  <= pending_d;
         sig_lost_q <= sig_lost_d;
         overrun_q  <= overrun_d;
      end
   end

   assign pending  = pending_q;
   assign width    = width_q;
   assign sig_lost = sig_lost_q;
   assign overrun  = overrun_q;

endmodule

// File: rtl/rc_pwm_capture_ctrl.sv
// RC PWM capture controller: 1 us tick prescaler, per-channel capture units,
// round-robin arbitration of finished captures onto a valid/ready result port.
module rc_pwm_capture_ctrl
   import fcu_rc_pkg::*;
#(
   parameter int CH_NUM   = 4,
   parameter int TICK_DIV = 50,
   parameter int MIN_US   = 800,
   parameter int MAX_US   = 2200,
   parameter int LOST_US  = 50000
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               Init_Rdy,
   input  logic [CH_NUM-1:0]  L2H_Sig,
   input  logic [CH_NUM-1:0]  H2L_Sig,
   output logic               Out_Valid,
   input  logic               Out_Ready,
   output logic [CHAN_W-1:0]  Out_Chan,
   output logic [WIDTH_W-1:0] Out_Width,
   output logic [CH_NUM-1:0]  Sig_Lost,
   output logic [CH_NUM-1:0]  Overrun,
   input  logic               Ovr_Clr
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PTR_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic               tick;
   logic [CH_NUM-1:0]  pending;
   logic [CH_NUM-1:0]  grant;
   logic [WIDTH_W-1:0] chan_width [CH_NUM];
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   cand;
   logic [PTR_W-1:0]   sel;
   logic               found;
   logic               load;
   logic               out_valid_q, out_valid_d;
   logic [CHAN_W-1:0]  out_chan_q, out_chan_d;
   logic [WIDTH_W-1:0] out_width_q, out_width_d;

   always_comb begin
      tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
      rc_chan_capture #(
         .MIN_US  (MIN_US),
         .MAX_US  (MAX_US),
         .LOST_US (LOST_US)
      ) u_chan (
         .clk      (CLK),
         .rst_n    (RSTn),
         .tick     (tick),
         .init_rdy (Init_Rdy),
         .l2h      (L2H_Sig[i]),
         .h2l      (H2L_Sig[i]),
         .grant    (grant[i]),
         .ovr_clr  (Ovr_Clr),
         .pending  (pending[i]),
         .width    (chan_width[i]),
         .sig_lost (Sig_Lost[i]),
         .overrun  (Overrun[i])
      );
   end

   // Output register only reloads when empty or being transferred, so a stalled result stays stable
   always_comb begin
      load  = !out_valid_q || Out_Ready;
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      grant = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         cand = PTR_W'((int'(rr_ptr_q) + k) % CH_NUM);
         if (!found && pending[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      out_valid_d = out_valid_q;
      out_chan_d  = out_chan_q;
      out_width_d = out_width_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = found;
         if (found) begin
            grant[sel]  = 1'b1;
            out_chan_d  = CHAN_W'(sel);
            out_width_d = chan_width[sel];
            rr_ptr_d    = (sel == PTR_W'(CH_NUM - 1)) ? '0 : sel + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         tick_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= '0;
         out_width_q <= '0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
         out_width_q <= out_width_d;
      end
   end

   assign Out_Valid = out_valid_q;
   assign Out_Chan  = out_chan_q;
   assign Out_Width = out_width_q;

endmodule

// File: tb/tb_rc_pwm_capture_ctrl.sv
// Directed bench for rc_pwm_capture_ctrl using a fast tick (2 clocks/us) and short loss timeout.
// Pulses of 2*W+1 clocks always measure exactly W us regardless of prescaler phase.
module tb_rc_pwm_capture_ctrl;

   localparam int CH_NUM   = 4;
   localparam int TICK_DIV = 2;
   localparam int LOST_US  = 2500;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_rdy;
   logic [3:0]  l2h;
   logic [3:0]  h2l;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_chan;
   logic [15:0] out_width;
   logic [3:0]  sig_lost;
   logic [3:0]  overrun;
   logic        ovr_clr;

   int num_checks = 0;
   int num_errors = 0;

   typedef struct {
      int ch;
      int us;
      bit exp_valid;
   } vec_t;

   vec_t vecs [7];

   rc_pwm_capture_ctrl #(
      .CH_NUM   (CH_NUM),
      .TICK_DIV (TICK_DIV),
      .MIN_US   (800),
      .MAX_US   (2200),
      .LOST_US  (LOST_US)
   ) dut (
      .CLK       (clk),
      .RSTn      (rst_n),
      .Init_Rdy  (init_rdy),
      .L2H_Sig   (l2h),
      .H2L_Sig   (h2l),
      .Out_Valid (out_valid),
      .Out_Ready (out_ready),
      .Out_Chan  (out_chan),
      .Out_Width (out_width),
      .Sig_Lost  (sig_lost),
      .Overrun   (overrun),
      .Ovr_Clr   (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      num_checks++;
      if (actual != expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      num_checks++;
      if (actual < lo || actual > hi) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " valid"}, int'(out_valid), 0);
      checkOutput({tag, " chan"}, int'(out_chan), 0);
      checkOutput({tag, " width"}, int'(out_width), 0);
      checkOutput({tag, " sig_lost"}, int'(sig_lost), 15);
      checkOutput({tag, " overrun"}, int'(overrun), 0);
   endtask

   // Rising strobes on mask, then falling strobes exactly 'cycles' clocks later
   task automatic applyStimulus(input logic [3:0] mask, input int cycles);
      l2h = mask;
      cycle();
      l2h = '0;
      repeat (cycles - 1) cycle();
      h2l = mask;
      cycle();
      h2l = '0;
   endtask

   task automatic waitResult(output bit got, output int ch, output int w);
      got = 1'b0;
      ch  = -1;
      w   = -1;
      for (int i = 0; i < 6 && !got; i++) begin
         cycle();
         if (out_valid) begin
            got = 1'b1;
            ch  = int'(out_chan);
            w   = int'(out_width);
         end
      end
   endtask

   task automatic expectNone(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (out_valid) seen++;
      end
      checkOutput(name, seen, 0);
   endtask

   initial begin
      bit got;
      int ch;
      int w;

      vecs[0] = '{1, 700, 1'b0};
      vecs[1] = '{1, 2300, 1'b0};
      vecs[2] = '{2, 799, 1'b0};
      vecs[3] = '{2, 800, 1'b1};
      vecs[4] = '{3, 2200, 1'b1};
      vecs[5] = '{3, 2201, 1'b0};
      vecs[6] = '{0, 1234, 1'b1};

      rst_n     = 1'b0;
      init_rdy  = 1'b1;
      l2h       = '0;
      h2l       = '0;
      out_ready = 1'b1;
      ovr_clr   = 1'b0;
      repeat (3) cycle();
      checkReset("reset");
      rst_n = 1'b1;
      cycle();

      // Unaligned 1500 us pulse on ch0
      applyStimulus(4'b0001, 1500 * TICK_DIV);
      waitResult(got, ch, w);
      checkOutput("t1 got", int'(got), 1);
      checkOutput("t1 chan", ch, 0);
      checkRange("t1 width", w, 1499, 1500);
      checkOutput("t1 sig_lost0", int'(sig_lost[0]), 0);

      for (int v = 0; v < 7; v++) begin
         applyStimulus(4'(1 << vecs[v].ch), 2 * vecs[v].us + 1);
         waitResult(got, ch, w);
         checkOutput($sformatf("vec%0d got", v), int'(got), int'(vecs[v].exp_valid));
         if (vecs[v].exp_valid) begin
            checkOutput($sformatf("vec%0d chan", v), ch, vecs[v].ch);
            checkOutput($sformatf("vec%0d width", v), w, vecs[v].us);
         end
      end
      checkOutput("t2 sig_lost1", int'(sig_lost[1]), 1);

      // Simultaneous falls on all channels, twice, from a fresh RR pointer
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();
      for (int r = 0; r < 2; r++) begin
         applyStimulus(4'hF, 2001);
         for (int k = 0; k < 4; k++) begin
            cycle();
            checkOutput($sformatf("t3 r%0d valid%0d", r, k), int'(out_valid), 1);
            checkOutput($sformatf("t3 r%0d chan%0d", r, k), int'(out_chan), k);
            checkOutput($sformatf("t3 r%0d width%0d", r, k), int'(out_width), 1000);
         end
         cycle();
         checkOutput($sformatf("t3 r%0d drained", r), int'(out_valid), 0);
      end

      // Backpressure on ch2: held output, pending, then overrun
      out_ready = 1'b0;
      applyStimulus(4'b0100, 2001);
      cycle();
      checkOutput("t4 valid", int'(out_valid), 1);
      checkOutput("t4 chan", int'(out_chan), 2);
      checkOutput("t4 width", int'(out_width), 1000);
      applyStimulus(4'b0100, 2401);
      cycle();
      checkOutput("t4 held width", int'(out_width), 1000);
      checkOutput("t4 no overrun", int'(overrun), 0);
      applyStimulus(4'b0100, 2801);
      cycle();
      checkOutput("t4 overrun", int'(overrun), 4);
      checkOutput("t4 held width2", int'(out_width), 1000);
      ovr_clr = 1'b1;
      cycle();
      ovr_clr = 1'b0;
      checkOutput("t4 ovr_clr", int'(overrun), 0);
      out_ready = 1'b1;
      cycle();
      checkOutput("t4 drain valid", int'(out_valid), 1);
      checkOutput("t4 drain width", int'(out_width), 1400);
      cycle();
      checkOutput("t4 drain empty", int'(out_valid), 0);

      // Init_Rdy dropped mid-pulse, then held low for a whole pulse
      l2h = 4'b0001;
      cycle();
      l2h = '0;
      repeat (500) cycle();
      init_rdy = 1'b0;
      repeat (10) cycle();
      init_rdy = 1'b1;
      repeat (2490) cycle();
      h2l = 4'b0001;
      cycle();
      h2l = '0;
      expectNone("t5 mid drop", 6);
      init_rdy = 1'b0;
      applyStimulus(4'b0001, 3001);
      expectNone("t5 init low", 6);
      init_rdy = 1'b1;
      applyStimulus(4'b0001, 3001);
      waitResult(got, ch, w);
      checkOutput("t5 got", int'(got), 1);
      checkOutput("t5 width", w, 1500);

      // Signal loss timing on ch3, then reset mid-pulse
      applyStimulus(4'b1000, 2001);
      waitResult(got, ch, w);
      checkOutput("t6 got", int'(got), 1);
      checkOutput("t6 width", w, 1000);
      checkOutput("t6 lost3 cleared", int'(sig_lost[3]), 0);
      repeat ((LOST_US - 20) * TICK_DIV) cycle();
      checkOutput("t6 lost3 early", int'(sig_lost[3]), 0);
      repeat (40 * TICK_DIV) cycle();
      checkOutput("t6 lost3 set", int'(sig_lost[3]), 1);
      l2h = 4'b0001;
      cycle();
      l2h = '0;
      repeat (200) cycle();
      rst_n = 1'b0;
      #1;
      checkReset("t6 reset");
      cycle();
      rst_n = 1'b1;
      repeat (2800) cycle();
      h2l = 4'b0001;
      cycle();
      h2l = '0;
      expectNone("t6 no partial", 6);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
